// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A/B operand pair for the matrix_multiply
// systolic array and replays it onto the array edges with diagonal skew.
// It also drives the array accumulator clear (mm_reset) and pulses done
// when the array results are final.
//
// Build option FEEDER_TRANSPOSE_B_EN:
//   defined   -> load_b beat k is row k of B (stored as B[k][*])
//   undefined -> load_b beat k is column k of B (stored as B[*][k])
// A is always loaded row-wise.

module systolic_feeder #(
  parameter int MATRIX_SIZE = 16,
  parameter int DATA_SIZE   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic signed [DATA_SIZE-1:0] load_a [MATRIX_SIZE-1:0],
  input  logic signed [DATA_SIZE-1:0] load_b [MATRIX_SIZE-1:0],
  output logic signed [DATA_SIZE-1:0] out_a  [MATRIX_SIZE-1:0],
  output logic signed [DATA_SIZE-1:0] out_b  [MATRIX_SIZE-1:0],
  output logic                        mm_reset,
  output logic                        busy,
  output logic                        done
);

  localparam int N      = MATRIX_SIZE;
  localparam int STEP_W = $clog2(3 * N);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic [STEP_W-1:0] LAST_BEAT = STEP_W'(N - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3 * N - 3);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  logic [STEP_W-1:0]   beat_r;
  logic [STEP_W-1:0]   step_r;
  logic [STEP_W-1:0]   drain_r;

  logic signed [DATA_SIZE-1:0] a_r [N-1:0][N-1:0];
  logic signed [DATA_SIZE-1:0] b_r [N-1:0][N-1:0];

  logic                        accept_s;
  logic [STEP_W-1:0]           feed_t_s;
  logic signed [DATA_SIZE-1:0] feed_a_s [N-1:0];
  logic signed [DATA_SIZE-1:0] feed_b_s [N-1:0];

  // A beat is taken only while waiting for operands.
  always_comb begin
    if (state_r == LOAD) begin
      accept_s = load_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Skewed edge vectors for the step that the next cycle will present:
  // step 0 when leaving CLEAR, otherwise the current step plus one.
  always_comb begin
    if (state_r == CLEAR) begin
      feed_t_s = '0;
    end else begin
      feed_t_s = step_r + STEP_W'(1);
    end
    for (int i = 0; i < N; i++) begin
      if ((int'(feed_t_s) >= i) && ((int'(feed_t_s) - i) < N)) begin
        feed_a_s[i] = a_r[i][IDX_W'(int'(feed_t_s) - i)];
        feed_b_s[i] = b_r[IDX_W'(int'(feed_t_s) - i)][i];
      end else begin
        feed_a_s[i] = '0;
        feed_b_s[i] = '0;
      end
    end
  end

  // Operand storage: clear on reset, write one row of A and one row or
  // column of B per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_r[r][c] <= '0;
          b_r[r][c] <= '0;
        end
      end
    end else if (accept_s) begin
      for (int c = 0; c < N; c++) begin
        a_r[IDX_W'(beat_r)][c] <= load_a[c];
`ifdef FEEDER_TRANSPOSE_B_EN
        b_r[IDX_W'(beat_r)][c] <= load_b[c];
`else
        b_r[c][IDX_W'(beat_r)] <= load_b[c];
`endif
      end
    end
  end

  // Sequencer: LOAD -> CLEAR -> FEED -> DRAIN -> LOAD. Outputs are
  // registered alongside the state so each state's values appear in the
  // cycle the state is occupied. mm_reset is held between operations so
  // the array keeps its final results after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= LOAD;
      beat_r     <= '0;
      step_r     <= '0;
      drain_r    <= '0;
      load_ready <= 1'b1;
      mm_reset   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        out_a[i] <= '0;
        out_b[i] <= '0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          done <= 1'b0;
          if (accept_s) begin
            if (beat_r == LAST_BEAT) begin
              state_r    <= CLEAR;
              beat_r     <= '0;
              load_ready <= 1'b0;
              busy       <= 1'b1;
              mm_reset   <= 1'b1;
            end else begin
              beat_r <= beat_r + STEP_W'(1);
            end
          end
        end
        CLEAR: begin
          state_r  <= FEED;
          step_r   <= '0;
          mm_reset <= 1'b0;
          for (int i = 0; i < N; i++) begin
            out_a[i] <= feed_a_s[i];
            out_b[i] <= feed_b_s[i];
          end
        end
        FEED: begin
          if (step_r == LAST_STEP) begin
            state_r <= DRAIN;
            drain_r <= '0;
            done    <= (N == 1);
            for (int i = 0; i < N; i++) begin
              out_a[i] <= '0;
              out_b[i] <= '0;
            end
          end else begin
            step_r <= step_r + STEP_W'(1);
            for (int i = 0; i < N; i++) begin
              out_a[i] <= feed_a_s[i];
              out_b[i] <= feed_b_s[i];
            end
          end
        end
        DRAIN: begin
          if (drain_r == LAST_BEAT) begin
            state_r    <= LOAD;
            done       <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            drain_r <= drain_r + STEP_W'(1);
            done    <= ((drain_r + STEP_W'(1)) == LAST_BEAT);
          end
        end
        default: begin
          state_r    <= LOAD;
          beat_r     <= '0;
          load_ready <= 1'b1;
          mm_reset   <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          for (int i = 0; i < N; i++) begin
            out_a[i] <= '0;
            out_b[i] <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=3, 8-bit elements).
// The reference model holds the logical A and B matrices and derives the
// expected per-cycle outputs from the operation timeline: one CLEAR cycle,
// 3N-2 FEED cycles with diagonal skew, N DRAIN cycles with done on the last.

module tb_systolic_feeder;

  localparam int N  = 3;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 load_valid;
  logic                 load_ready;
  logic signed [DW-1:0] load_a [N-1:0];
  logic signed [DW-1:0] load_b [N-1:0];
  logic signed [DW-1:0] out_a  [N-1:0];
  logic signed [DW-1:0] out_b  [N-1:0];
  logic                 mm_reset;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;

  // logical operand matrices: ma[row][col], mb[row][col]
  int ma [N][N];
  int mb [N][N];

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_a     (load_a),
    .load_b     (load_b),
    .out_a      (out_a),
    .out_b      (out_b),
    .mm_reset   (mm_reset),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic junk_inputs();
    for (int j = 0; j < N; j++) begin
      load_a[j] = DW'($urandom_range(0, 255));
      load_b[j] = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_beat(input int k);
    for (int j = 0; j < N; j++) begin
      load_a[j] = DW'(ma[k][j]);
`ifdef FEEDER_TRANSPOSE_B_EN
      load_b[j] = DW'(mb[k][j]);
`else
      load_b[j] = DW'(mb[j][k]);
`endif
    end
    load_valid = 1'b1;
  endtask

  // gap_mode 0: back-to-back, 1: one idle cycle between beats, 2: random gaps.
  // Returns with the last beat driven, just before the accepting edge.
  task automatic load_op(input int gap_mode);
    int gaps;
    int w;
    for (int k = 0; k < N; k++) begin
      gaps = 0;
      if (k > 0 && gap_mode == 1) gaps = 1;
      if (k > 0 && gap_mode == 2) gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        load_valid = 1'b0;
        junk_inputs();
        @(posedge clk); #1;
      end
      w = 0;
      while (load_ready !== 1'b1 && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      total++;
      if (load_ready !== 1'b1) begin
        bad++;
        $display("FAIL load_wait beat=%0d load_ready=%b want 1", k, load_ready);
      end
      drive_beat(k);
      if (k < N - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Follows one operation from the accepting edge of the last beat through
  // the first LOAD cycle after done, checking every output in every cycle.
  task automatic play_op(input bit hold_valid);
    int t;
    int ea;
    int eb;
    bit feed;
    logic signed [DW-1:0] xa;
    logic signed [DW-1:0] xb;
    @(posedge clk); #1;
    load_valid = hold_valid;
    junk_inputs();
    for (int c = 1; c <= 4 * N; c++) begin
      @(negedge clk);
      feed = (c >= 2) && (c <= 3 * N - 1);
      t = c - 2;
      total++;
      if (load_ready !== (c == 4 * N)) begin
        bad++;
        $display("FAIL load_ready c=%0d got=%b want=%b", c, load_ready, (c == 4 * N));
      end
      total++;
      if (busy !== (c < 4 * N)) begin
        bad++;
        $display("FAIL busy c=%0d got=%b want=%b", c, busy, (c < 4 * N));
      end
      total++;
      if (done !== (c == 4 * N - 1)) begin
        bad++;
        $display("FAIL done c=%0d got=%b want=%b", c, done, (c == 4 * N - 1));
      end
      total++;
      if (mm_reset !== (c == 1)) begin
        bad++;
        $display("FAIL mm_reset c=%0d got=%b want=%b", c, mm_reset, (c == 1));
      end
      for (int i = 0; i < N; i++) begin
        ea = 0;
        eb = 0;
        if (feed && (t - i) >= 0 && (t - i) < N) begin
          ea = ma[i][t - i];
          eb = mb[t - i][i];
        end
        xa = DW'(ea);
        xb = DW'(eb);
        total++;
        if (out_a[i] !== xa) begin
          bad++;
          $display("FAIL out_a[%0d] c=%0d got=%0d want=%0d", i, c, out_a[i], xa);
        end
        total++;
        if (out_b[i] !== xb) begin
          bad++;
          $display("FAIL out_b[%0d] c=%0d got=%0d want=%0d", i, c, out_b[i], xb);
        end
      end
      @(posedge clk); #1;
      if (c == 3 * N - 1) load_valid = 1'b0;
    end
  endtask

  task automatic set_random_matrices();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ma[r][c] = int'($urandom_range(0, 255)) - 128;
        mb[r][c] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  task automatic set_skew_matrices();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ma[r][c] = r * N + c + 1;
        mb[r][c] = (r == c) ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    junk_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
    total++;
    if (mm_reset !== 1'b1) begin bad++; $display("FAIL reset_mm_reset got=%b want=1", mm_reset); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (out_a[i] !== 8'sd0) begin bad++; $display("FAIL reset_out_a[%0d] got=%0d want=0", i, out_a[i]); end
      total++;
      if (out_b[i] !== 8'sd0) begin bad++; $display("FAIL reset_out_b[%0d] got=%0d want=0", i, out_b[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_skew();
    set_skew_matrices();
    load_op(0);
    play_op(1'b0);
  endtask

  task automatic test_handshake_gaps();
    set_skew_matrices();
    load_op(1);
    play_op(1'b1);
  endtask

  task automatic test_signed();
    set_random_matrices();
    ma[0][0] = -128; ma[0][1] = 127; ma[0][2] = -1;
    ma[1][0] = 0;    ma[1][1] = -1;  ma[1][2] = 127;
    ma[2][0] = -128; ma[2][1] = 0;   ma[2][2] = 1;
    mb[0][0] = 127;  mb[1][1] = -128;
    load_op(0);
    play_op(1'b0);
  endtask

  task automatic test_reset_mid_feed();
    set_random_matrices();
    load_op(0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    // now in FEED step t=2; abort on the next edge
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL abort_load_ready got=%b want=1", load_ready); end
    total++;
    if (mm_reset !== 1'b1) begin bad++; $display("FAIL abort_mm_reset got=%b want=1", mm_reset); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (out_a[i] !== 8'sd0 || out_b[i] !== 8'sd0) begin
        bad++;
        $display("FAIL abort_out[%0d] got a=%0d b=%0d want 0", i, out_a[i], out_b[i]);
      end
    end
    for (int c = 0; c < 4 * N; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || load_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_idle c=%0d got done=%b ready=%b want done=0 ready=1", c, done, load_ready);
      end
    end
    @(posedge clk); #1;
    // two partial beats, then reset coincident with the third beat
    set_random_matrices();
    drive_beat(0);
    @(posedge clk); #1;
    drive_beat(1);
    @(posedge clk); #1;
    drive_beat(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_beat_drop got busy=%b ready=%b want busy=0 ready=1", busy, load_ready);
    end
    // a fresh full load must play out correctly
    set_random_matrices();
    load_op(0);
    play_op(1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      set_random_matrices();
      load_op(2);
      play_op(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    junk_inputs();
    test_reset();
    test_skew();
    test_handshake_gaps();
    test_signed();
    test_reset_mid_feed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
